// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//
// Shared types for the radix-8 Booth multiplier slice.
//
//   t_enc_out    : output of the Booth digit encoder. code is the magnitude
//                  of the selected multiple (0..4 times the multiplicand)
//                  and sign asks the datapath to negate that multiple.
//   t_mult_state : control states of the sequential multiplier.
//   calcDigits   : number of radix-8 digits needed to cover an operand of
//                  the given width plus one extension bit, so that unsigned
//                  operands still see a non-negative top digit.
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef struct packed {
    logic [2:0] code;
    logic       sign;
  } t_enc_out;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } t_mult_state;

  // ceil((width + 1) / 3) written without a real-valued ceiling so it can
  // be evaluated inside localparam expressions.
  function automatic int calcDigits(input int width);
    return (width + 3) / 3;
  endfunction

endpackage

// File: rtl/booth_encoder.sv
// ---------------------------------------------------------------------------
// booth_encoder
//
// Radix-8 Modified-Booth digit encoder. The 4-bit window holds three
// multiplier bits plus the bit just below them; its value is
//   -4*w[3] + 2*w[2] + w[1] + w[0]
// which lies in -4..+4. The encoder splits that into a magnitude and a sign.
//
// Ports:
//   i_window : 4-bit Booth window, bit 0 is the previous (lower) bit
//   o_enc    : magnitude code 0..4 and negate flag
// ---------------------------------------------------------------------------
module booth_encoder
  import booth_pkg::*;
(
  input  logic [3:0] i_window,
  output t_enc_out   o_enc
);

  // Pure lookup from window to signed digit. The all-ones window is a
  // digit of zero and is reported with sign 0 so the datapath never has
  // to negate a zero multiple. Window 1000 is the only -4X case.
  always_comb begin
    o_enc = '0;
    case (i_window)
      4'b0000, 4'b1111: o_enc = '{code: 3'd0, sign: 1'b0};
      4'b0001, 4'b0010: o_enc = '{code: 3'd1, sign: 1'b0};
      4'b0011, 4'b0100: o_enc = '{code: 3'd2, sign: 1'b0};
      4'b0101, 4'b0110: o_enc = '{code: 3'd3, sign: 1'b0};
      4'b0111:          o_enc = '{code: 3'd4, sign: 1'b0};
      4'b1000:          o_enc = '{code: 3'd4, sign: 1'b1};
      4'b1001, 4'b1010: o_enc = '{code: 3'd3, sign: 1'b1};
      4'b1011, 4'b1100: o_enc = '{code: 3'd2, sign: 1'b1};
      4'b1101, 4'b1110: o_enc = '{code: 3'd1, sign: 1'b1};
    endcase
  end

endmodule

// File: rtl/booth_r8_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_r8_seq_mult
//
// Iterative radix-8 Modified-Booth multiplier, one Booth digit per clock.
// Operands are both signed or both unsigned, selected per transaction by
// in_signed. The product is exact and 2*WIDTH bits wide.
//
// Flow: IDLE accepts an operand pair, PRE forms the 3X hard multiple,
// RUN retires DIGITS Booth digits into the accumulator, DONE presents the
// product until the consumer takes it.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operand pair valid
//   in_ready  : high only in IDLE, the block holds one operation at a time
//   in_signed : 1 = two's complement operands, 0 = unsigned operands
//   in_a      : multiplicand, WIDTH bits
//   in_b      : multiplier, WIDTH bits
//   out_valid : product valid, high only in DONE
//   out_ready : consumer accepts product
//   out_prod  : product, 2*WIDTH bits, holds the last result until reloaded
// ---------------------------------------------------------------------------
module booth_r8_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int DIGITS = calcDigits(WIDTH);
  localparam int AW     = WIDTH + 1;
  localparam int TW     = WIDTH + 3;
  localparam int PW     = WIDTH + 4;
  localparam int BW     = 3 * DIGITS + 1;
  localparam int EB     = 3 * DIGITS - WIDTH;
  localparam int ACCW   = 2 * WIDTH + 4;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW     = $clog2(ACCW);

  t_mult_state        r_state;
  t_mult_state        w_nextState;

  logic [AW-1:0]      r_a;
  logic [TW-1:0]      r_a3;
  logic [BW-1:0]      r_bExt;
  logic [ACCW-1:0]    r_acc;
  logic [CW-1:0]      r_digitCnt;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_lastDigit;
  t_enc_out           w_enc;
  logic [PW-1:0]      w_ppSel;
  logic [PW-1:0]      w_ppInv;
  logic [ACCW-1:0]    w_ppExt;
  logic [SW-1:0]      w_shamt;
  logic [ACCW-1:0]    w_ppShift;
  logic [ACCW-1:0]    w_carry;
  logic [ACCW-1:0]    w_accNext;

  // The multiplier register shifts right by one digit per RUN cycle, so
  // the current Booth window is always its bottom four bits. The appended
  // zero LSB made at capture time serves as the "previous bit" of digit 0.
  booth_encoder u_enc (
    .i_window (r_bExt[3:0]),
    .o_enc    (w_enc)
  );

  assign w_lastDigit = (r_digitCnt == CW'(DIGITS - 1));
  assign out_prod    = r_prod;

  // State register. Reset drops straight back to IDLE from anywhere so an
  // interrupted operation never produces an output pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. in_ready is only offered in IDLE
  // because there is no operand buffering; out_valid is exactly "in DONE",
  // so leaving DONE on the output handshake drops it on the same edge.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_nextState = PRE;
        end
      end
      PRE: begin
        w_nextState = RUN;
      end
      RUN: begin
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Partial-product selection. All multiples are brought to WIDTH+4 bits,
  // which is enough to hold +/-4X of a WIDTH+1 bit multiplicand including
  // the most negative signed value. 3X is the only multiple that is not a
  // plain shift, which is why it is precomputed in PRE.
  always_comb begin
    w_ppSel = '0;
    case (w_enc.code)
      3'd1:    w_ppSel = {{3{r_a[AW-1]}}, r_a};
      3'd2:    w_ppSel = {{2{r_a[AW-1]}}, r_a, 1'b0};
      3'd3:    w_ppSel = {r_a3[TW-1], r_a3};
      3'd4:    w_ppSel = {r_a[AW-1], r_a, 2'b00};
      default: w_ppSel = '0;
    endcase
  end

  // Negation is done as invert here plus a carry-in of one at the digit's
  // weight, so only a single adder is needed per digit. The sign-extended
  // inverted multiple and the carry are both shifted to weight 8^i.
  always_comb begin
    w_ppInv   = w_ppSel ^ {PW{w_enc.sign}};
    w_ppExt   = {{(ACCW - PW){w_ppInv[PW-1]}}, w_ppInv};
    w_shamt   = SW'(3 * r_digitCnt);
    w_ppShift = w_ppExt << w_shamt;
    w_carry   = {{(ACCW - 1){1'b0}}, w_enc.sign} << w_shamt;
    w_accNext = r_acc + w_ppShift + w_carry;
  end

  // Datapath registers. At accept the multiplicand is extended by one bit
  // and the multiplier out to a whole number of digits, both using the
  // captured signedness, so nothing later depends on in_signed, in_a or
  // in_b. The accumulator runs modulo 2^(2*WIDTH+4) and only its low
  // 2*WIDTH bits are kept, which is exact because the true product fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_a3       <= '0;
      r_bExt     <= '0;
      r_acc      <= '0;
      r_digitCnt <= '0;
      r_prod     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a        <= {in_signed & in_a[WIDTH-1], in_a};
            r_bExt     <= {{EB{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
            r_acc      <= '0;
            r_digitCnt <= '0;
          end
        end
        PRE: begin
          r_a3 <= {{2{r_a[AW-1]}}, r_a} + {r_a[AW-1], r_a, 1'b0};
        end
        RUN: begin
          r_acc  <= w_accNext;
          r_bExt <= r_bExt >> 3;
          if (w_lastDigit) begin
            r_prod <= w_accNext[2*WIDTH-1:0];
          end else begin
            r_digitCnt <= r_digitCnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_booth_r8_seq_mult
//
// Self-checking bench for booth_r8_seq_mult at WIDTH=16. Expected products
// come from a vector table or from a 64-bit integer reference multiply and
// are queued when an operand pair is accepted; a monitor pops and compares
// them on every output handshake.
// ---------------------------------------------------------------------------
module tb_booth_r8_seq_mult;

  localparam int W       = 16;
  localparam int DIGITS  = (W + 3) / 3;
  localparam int LAT     = DIGITS + 2;
  localparam int SPACING = DIGITS + 3;
  localparam int NVEC    = 13;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    string          name;
  } t_vec;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_signed = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_prod;

  int             checks = 0;
  int             errors = 0;
  int             hsCount = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] expNext = '0;
  t_vec           vecs[NVEC];

  booth_r8_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case some wait is ever left unbounded by mistake.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: extend both operands to 64 bits according to the
  // signedness and multiply as integers.
  function automatic logic [2*W-1:0] refMul(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa;
    longint pb;
    longint p;
    pa = sgn ? {{(64 - W){a[W-1]}}, a} : {{(64 - W){1'b0}}, a};
    pb = sgn ? {{(64 - W){b[W-1]}}, b} : {{(64 - W){1'b0}}, b};
    p  = pa * pb;
    return p[2*W-1:0];
  endfunction

  // One comparison: counts it, and reports it when actual differs.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A bound that expired is a failed comparison.
  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard monitor, sampling on the falling edge. An accept seen here
  // happens on the next rising edge, so the expected product is queued
  // now; likewise an output handshake is scored against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        expQ.push_back(expNext);
      end
      if (out_valid && out_ready) begin
        hsCount++;
        if (expQ.size() == 0) begin
          timeoutFail("prod_unexpected");
        end else begin
          checkOutput("prod", out_prod, expQ.pop_front());
        end
      end
    end
  end

  // Present one operand pair until accepted, then scramble the inputs so
  // that a design still looking at them after accept gets a wrong answer.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int waitCnt;
    @(posedge clk);
    #1;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    expNext   = exp;
    in_valid  = 1'b1;
    waitCnt   = 0;
    @(negedge clk);
    while (!in_ready && waitCnt < 4 * SPACING) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      timeoutFail("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_signed = ~sgn;
      in_a      = ~a;
      in_b      = ~b;
    end
  endtask

  // Wait until the monitor has scored one more output handshake.
  task automatic waitDone(input int budget);
    int start;
    int n;
    start = hsCount;
    n = 0;
    while (hsCount == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (hsCount == start) begin
      timeoutFail("done_timeout");
    end
  endtask

  // Accept from IDLE and record out_valid / in_ready in each of the cycles
  // 1..LAT after the accept cycle; out_valid must first appear in cycle
  // LAT and in_ready must stay low throughout. out_ready is high, so the
  // handshake follows and the block is back in IDLE one cycle later.
  task automatic runTimed(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    logic [LAT-1:0] ovSeq;
    logic [LAT-1:0] irSeq;
    logic [LAT-1:0] ovExp;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    expNext   = exp;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_signed = ~sgn;
    in_a      = ~a;
    in_b      = ~b;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      ovSeq[c] = out_valid;
      irSeq[c] = in_ready;
    end
    ovExp = '0;
    ovExp[LAT-1] = 1'b1;
    checkOutput({tag, "_out_valid_profile"}, 64'(ovSeq), 64'(ovExp));
    checkOutput({tag, "_in_ready_profile"}, 64'(irSeq), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_idle_after"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [2*W-1:0] bpExp;
    int             n;
    int             bad;
    int             hsBefore;
    time            tPrev;
    time            tNow;
    logic           rs;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    vecs = '{
      '{1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1, "s_3_x_m5"},
      '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u_max_sq"},
      '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "s_m1_sq"},
      '{1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_min_sq"},
      '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, "s_max_x_min"},
      '{1'b0, 16'h8000, 16'h8000, 32'h40000000, "u_msb_sq"},
      '{1'b1, 16'h8000, 16'h0002, 32'hFFFF0000, "s_min_x_2"},
      '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF, "u_max_x_1"},
      '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF, "s_m1_x_1"},
      '{1'b0, 16'h0005, 16'h0004, 32'h00000014, "u_5_x_4"},
      '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, "s_max_sq"},
      '{1'b0, 16'h0000, 16'hFFFF, 32'h00000000, "u_zero"},
      '{1'b1, 16'h0123, 16'hFED4, 32'hFFFEAAFC, "s_291_x_m300"}
    };

    $display("[TB] reset check");
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_prod", 64'(out_prod), 64'd0);
    rst = 1'b0;

    $display("[TB] latency sequence");
    runTimed("lat", 1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1);

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
      waitDone(4 * SPACING);
    end

    // 1234 * 567 = 699678 = 0x000AAD1E, held under backpressure.
    $display("[TB] backpressure");
    bpExp = 32'h000AAD1E;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 16'd1234, 16'd567, bpExp);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 4 * SPACING) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      timeoutFail("bp_valid_timeout");
    end
    hsBefore = hsCount;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_prod !== bpExp) begin
        bad++;
      end
    end
    checkOutput("bp_hold_bad_cycles", 64'(bad), 64'd0);
    checkOutput("bp_prod_held", 64'(out_prod), 64'(bpExp));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDone(4 * SPACING);
    repeat (3) @(negedge clk);
    checkOutput("bp_single_handshake", 64'(hsCount - hsBefore), 64'd1);
    checkOutput("bp_valid_dropped", 64'(out_valid), 64'd0);
    checkOutput("prod_retained", 64'(out_prod), 64'(bpExp));

    // Cycle 5 after accept is RUN digit 3.
    $display("[TB] reset during RUN");
    applyStimulus(1'b1, 16'd100, 16'hFF38, refMul(1'b1, 16'd100, 16'hFF38));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_prod", 64'(out_prod), 64'd0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runTimed("post_rst", 1'b0, 16'd7, 16'd9, 32'd63);

    $display("[TB] back-to-back random");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tPrev = 0;
    for (int i = 0; i < 100; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      in_signed = rs;
      in_a      = ra;
      in_b      = rb;
      expNext   = refMul(rs, ra, rb);
      in_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 4 * SPACING) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        timeoutFail("b2b_accept_timeout");
        break;
      end
      @(posedge clk);
      tNow = $time;
      #1;
      if (i > 0) begin
        checkOutput("b2b_spacing", 64'((tNow - tPrev) / 10), 64'(SPACING));
      end
      tPrev = tNow;
    end
    in_valid = 1'b0;
    waitDone(4 * SPACING);
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
